apb_ram_arbiter: RTL and testbench

APB master-side arbiter that shares one APB completer (the APB RAM slave) among NREQ local requesters. Picks one pending request round-robin, runs a single APB transfer (SETUP then ACCESS, wait for PREADY), and returns read data and error status to the granted requester. Sits between the bus-master clients and the RAM's APB port.

---
 rtl/apb_ram_arbiter_pkg.sv | 19 +
 rtl/apb_ram_arbiter_if.sv | 24 ++
 rtl/apb_ram_arbiter_rr_arbiter.sv | 41 ++++
 rtl/apb_ram_arbiter.sv | 128 ++++++++++++
 tb/tb_apb_ram_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_ram_arbiter_pkg.sv
// Shared types and width defaults for the APB RAM arbiter.
// The optional ACCESS timeout is enabled by defining APB_ARB_TIMEOUT_EN.
package apb_arb_pkg;

  localparam int ADDR_WD_DEF = 8;
  localparam int DATA_WD_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_ACCESS   = 2'd2,
    ST_COMPLETE = 2'd3
  } arb_state_e;

  function automatic int idx_wd(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_ram_arbiter_if.sv
// APB bus bundle between the arbiter (master) and the RAM completer (slave).
interface apb_ram_arbiter_if #(
  parameter int ADDR_WD = 8,
  parameter int DATA_WD = 32
);
  logic               PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [ADDR_WD-1:0] PADDR;
  logic [DATA_WD-1:0] PWDATA;
  logic [DATA_WD-1:0] PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_ram_arbiter_rr_arbiter.sv
// Round-robin picker: scans upward from (last grant + 1) with wrap.
// The pointer moves only when the caller strobes upd on a real grant.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW  = idx_wd(NREQ)
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = found ? (NREQ'(1) << gnt_idx) : '0;
  end

  // Reset to the top index so requester 0 has first priority.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)  ptr <= IW'(NREQ - 1);
    else if (upd)  ptr <= gnt_idx;
  end

endmodule

// File: rtl/apb_ram_arbiter.sv
// Shares one APB completer among NREQ requesters, one transfer at a time.
// Define APB_ARB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT cycles.
module apb_ram_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WD = ADDR_WD_DEF,
  parameter int DATA_WD = DATA_WD_DEF,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16,
  localparam int IW     = idx_wd(NREQ)
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [NREQ-1:0]                REQ_VALID,
  input  logic [NREQ-1:0]                REQ_WRITE,
  input  logic [NREQ-1:0][ADDR_WD-1:0]   REQ_ADDR,
  input  logic [NREQ-1:0][DATA_WD-1:0]   REQ_WDATA,
  output logic [NREQ-1:0]                REQ_DONE,
  output logic [DATA_WD-1:0]             RSP_RDATA,
  output logic                           RSP_ERR,
  apb_ram_arbiter_if.master              apb
);

  localparam logic [1:0] IDLE     = ST_IDLE;
  localparam logic [1:0] SETUP    = ST_SETUP;
  localparam logic [1:0] ACCESS   = ST_ACCESS;
  localparam logic [1:0] COMPLETE = ST_COMPLETE;

  logic [1:0]         state;
  logic [NREQ-1:0]    gnt_q;
  logic               psel, penable, pwrite;
  logic [ADDR_WD-1:0] paddr;
  logic [DATA_WD-1:0] pwdata;
  logic [NREQ-1:0]    rr_gnt;
  logic [IW-1:0]      rr_idx;
  logic               grant_en;

  assign grant_en = (state == IDLE) && (|REQ_VALID);

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .req     (REQ_VALID),
    .upd     (grant_en),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      gnt_q     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      REQ_DONE  <= '0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      REQ_DONE <= '0;
      case (state)
        IDLE: begin
          if (grant_en) begin
            gnt_q  <= rr_gnt;
            pwrite <= REQ_WRITE[rr_idx];
            paddr  <= REQ_ADDR[rr_idx];
            pwdata <= REQ_WDATA[rr_idx];
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          to_cnt  <= '0;
`endif
        end
        ACCESS: begin
          if (apb.PREADY) begin
            psel     <= 1'b0;
            penable  <= 1'b0;
            REQ_DONE <= gnt_q;
            RSP_ERR  <= apb.PSLVERR;
            if (!pwrite) RSP_RDATA <= apb.PRDATA;
            state    <= COMPLETE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          // Completer never answered: report an error with zeroed data.
          else if (to_cnt == TO_LAST) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            REQ_DONE  <= gnt_q;
            RSP_ERR   <= 1'b1;
            RSP_RDATA <= '0;
            state     <= COMPLETE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        COMPLETE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign apb.PSEL    = psel;
  assign apb.PENABLE = penable;
  assign apb.PWRITE  = pwrite;
  assign apb.PADDR   = paddr;
  assign apb.PWDATA  = pwdata;

endmodule

// File: tb/tb_apb_ram_arbiter.sv
// Directed bench for apb_ram_arbiter with a small wait-state/error APB RAM model.
module tb_apb_ram_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [1:0]  REQ_VALID, REQ_WRITE;
  logic [15:0] REQ_ADDR;
  logic [63:0] REQ_WDATA;
  logic [1:0]  REQ_DONE;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  int ncomp = 0;
  int nfail = 0;
  int lat;

  apb_ram_arbiter_if #(.ADDR_WD(8), .DATA_WD(32)) apb ();

  apb_ram_arbiter #(.ADDR_WD(8), .DATA_WD(32), .NREQ(2), .TIMEOUT(16)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .REQ_VALID (REQ_VALID),
    .REQ_WRITE (REQ_WRITE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .REQ_DONE  (REQ_DONE),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERR   (RSP_ERR),
    .apb       (apb)
  );

  always #5 PCLK = ~PCLK;

  // Completer model: wait_n wait states, optional error, optional stall.
  logic [31:0] mem [256];
  int          wait_n     = 0;
  bit          err_mode   = 1'b0;
  bit          hold_ready = 1'b0;
  int          wcnt       = 0;

  assign apb.PREADY  = apb.PSEL && apb.PENABLE && !hold_ready && (wcnt >= wait_n);
  assign apb.PRDATA  = mem[apb.PADDR];
  assign apb.PSLVERR = err_mode && apb.PSEL && apb.PENABLE;

  always @(posedge PCLK) begin
    if (apb.PSEL && apb.PENABLE && !apb.PREADY) wcnt <= wcnt + 1;
    else                                        wcnt <= 0;
    if (apb.PSEL && apb.PENABLE && apb.PREADY && apb.PWRITE) mem[apb.PADDR] <= apb.PWDATA;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    while (REQ_DONE == 2'b00 && n < maxc) begin
      step();
      n++;
    end
    chk("done_seen", 64'(REQ_DONE != 2'b00), 64'd1);
  endtask

  task automatic set_req(input int i, input bit wr, input logic [7:0] a, input logic [31:0] d);
    REQ_WRITE[i]         = wr;
    REQ_ADDR[i*8 +: 8]   = a;
    REQ_WDATA[i*32 +: 32] = d;
  endtask

  task automatic go_idle();
    REQ_VALID = 2'b00;
    step();
  endtask

  initial begin
    PRESETn   = 1'b0;
    REQ_VALID = '0;
    REQ_WRITE = '0;
    REQ_ADDR  = '0;
    REQ_WDATA = '0;
    #1;
    chk("rst_psel",   64'(apb.PSEL),    64'd0);
    chk("rst_pen",    64'(apb.PENABLE), 64'd0);
    chk("rst_pwrite", 64'(apb.PWRITE),  64'd0);
    chk("rst_paddr",  64'(apb.PADDR),   64'd0);
    chk("rst_pwdata", 64'(apb.PWDATA),  64'd0);
    chk("rst_done",   64'(REQ_DONE),    64'd0);
    chk("rst_rdata",  64'(RSP_RDATA),   64'd0);
    chk("rst_err",    64'(RSP_ERR),     64'd0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    step();

    // Write 0xDEADBEEF to 0x10 from req0, then read it back.
    set_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
    REQ_VALID = 2'b01;
    step();
    chk("wr_setup_psel", 64'({apb.PSEL, apb.PENABLE}), 64'b10);
    chk("wr_setup_paddr", 64'(apb.PADDR), 64'h10);
    chk("wr_setup_pwrite", 64'(apb.PWRITE), 64'd1);
    wait_done(10, lat);
    chk("wr_latency", 64'(lat + 1), 64'd3);
    chk("wr_done", 64'(REQ_DONE), 64'b01);
    chk("wr_psel_drop", 64'(apb.PSEL), 64'd0);
    set_req(0, 1'b0, 8'h10, 32'h0);
    step();
    chk("done_one_cycle", 64'(REQ_DONE), 64'd0);
    wait_done(10, lat);
    chk("rd_latency", 64'(lat), 64'd3);
    chk("rd_done", 64'(REQ_DONE), 64'b01);
    chk("rd_data", 64'(RSP_RDATA), 64'hDEADBEEF);
    chk("rd_err", 64'(RSP_ERR), 64'd0);
    go_idle();

    // Both requesters valid from reset: grants alternate 0,1,0,1.
    PRESETn = 1'b0;
    step();
    PRESETn = 1'b1;
    set_req(0, 1'b1, 8'h20, 32'hA5A50020);
    set_req(1, 1'b1, 8'h30, 32'h5A5A0030);
    REQ_VALID = 2'b11;
    for (int t = 0; t < 4; t++) begin
      if (t != 0) step();
      wait_done(10, lat);
      chk("rr_period", 64'(lat), (t == 0) ? 64'd3 : 64'd3);
      chk("rr_grant", 64'(REQ_DONE), (t % 2 == 0) ? 64'b01 : 64'b10);
      chk("rr_paddr", 64'(apb.PADDR), (t % 2 == 0) ? 64'h20 : 64'h30);
      chk("rr_pwdata", 64'(apb.PWDATA), (t % 2 == 0) ? 64'hA5A50020 : 64'h5A5A0030);
    end
    go_idle();

    // Three completer wait states: four stable ACCESS cycles.
    wait_n = 3;
    set_req(0, 1'b0, 8'h10, 32'h0);
    REQ_VALID = 2'b01;
    step();
    chk("ws_setup", 64'({apb.PSEL, apb.PENABLE}), 64'b10);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("ws_access", 64'({apb.PSEL, apb.PENABLE}), 64'b11);
      chk("ws_paddr", 64'(apb.PADDR), 64'h10);
      chk("ws_nodone", 64'(REQ_DONE), 64'd0);
    end
    step();
    chk("ws_done", 64'(REQ_DONE), 64'b01);
    chk("ws_rdata", 64'(RSP_RDATA), 64'hDEADBEEF);
    chk("ws_psel", 64'(apb.PSEL), 64'd0);
    go_idle();

    // Slave error on read returns PRDATA; on write leaves RSP_RDATA alone.
    wait_n   = 0;
    err_mode = 1'b1;
    set_req(1, 1'b0, 8'h30, 32'h0);
    REQ_VALID = 2'b10;
    wait_done(10, lat);
    chk("err_rd_done", 64'(REQ_DONE), 64'b10);
    chk("err_rd_err", 64'(RSP_ERR), 64'd1);
    chk("err_rd_data", 64'(RSP_RDATA), 64'h5A5A0030);
    go_idle();
    set_req(1, 1'b1, 8'h40, 32'h00000055);
    REQ_VALID = 2'b10;
    wait_done(10, lat);
    chk("err_wr_err", 64'(RSP_ERR), 64'd1);
    chk("err_wr_rdata_hold", 64'(RSP_RDATA), 64'h5A5A0030);
    err_mode = 1'b0;
    go_idle();

    // Reset during ACCESS of a req0 transfer; afterwards req0 wins again.
    wait_n = 5;
    set_req(0, 1'b0, 8'h10, 32'h0);
    REQ_VALID = 2'b01;
    step();
    step();
    chk("rst_mid_access", 64'({apb.PSEL, apb.PENABLE}), 64'b11);
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_ctrl", 64'({apb.PSEL, apb.PENABLE, apb.PWRITE}), 64'd0);
    chk("rst_mid_paddr", 64'(apb.PADDR), 64'd0);
    chk("rst_mid_rdata", 64'(RSP_RDATA), 64'd0);
    chk("rst_mid_err", 64'(RSP_ERR), 64'd0);
    wait_n = 0;
    set_req(1, 1'b0, 8'h30, 32'h0);
    REQ_VALID = 2'b11;
    step();
    chk("rst_mid_nodone", 64'(REQ_DONE), 64'd0);
    PRESETn = 1'b1;
    wait_done(10, lat);
    chk("rst_after_grant", 64'(REQ_DONE), 64'b01);
    chk("rst_after_lat", 64'(lat), 64'd3);
    chk("rst_after_rdata", 64'(RSP_RDATA), 64'hDEADBEEF);
    go_idle();

`ifdef APB_ARB_TIMEOUT_EN
    // Completer never ready: forced completion after 16 ACCESS cycles.
    hold_ready = 1'b1;
    set_req(0, 1'b0, 8'h10, 32'h0);
    REQ_VALID = 2'b01;
    wait_done(40, lat);
    chk("to_latency", 64'(lat), 64'd18);
    chk("to_err", 64'(RSP_ERR), 64'd1);
    chk("to_rdata", 64'(RSP_RDATA), 64'd0);
    chk("to_psel", 64'(apb.PSEL), 64'd0);
    hold_ready = 1'b0;
    go_idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
